// File: rtl/hazard_ctrl.sv
// Hazard controller at the RR->EX boundary: shadow scoreboard of EX/MEM/WB, forwarding, stalls, flushes.
// Optional performance counters are built only when HAZ_PERF_EN is defined.
module hazard_ctrl #(
    parameter int REG_BITS     = 3,
    parameter int REDIRECT_LAT = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rr_valid,
    input  logic [REG_BITS-1:0] rr_rs1,
    input  logic [REG_BITS-1:0] rr_rs2,
    input  logic                rr_use_rs1,
    input  logic                rr_use_rs2,
    input  logic [REG_BITS-1:0] rr_rd,
    input  logic                rr_wr_en,
    input  logic                rr_is_load,
    input  logic                rr_wr_flags,
    input  logic                rr_flag_dep,
    input  logic                ex_branch,
    output logic                stall,
    output logic                ex_bubble,
    output logic                flush,
    output logic [1:0]          fwd1_sel,
    output logic [1:0]          fwd2_sel,
    output logic [1:0]          flag_fwd_sel,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [2:0] REDIR_INIT = 3'(REDIRECT_LAT);

    state_t              state_q;
    logic [2:0]          redir_cnt_q;

    logic                ex_vld_q, mem_vld_q, wb_vld_q;
    logic                ex_vld_d;
    logic [REG_BITS-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic                ex_wr_q, mem_wr_q, wb_wr_q;
    logic                ex_ld_q;
    logic                ex_wf_q, mem_wf_q, wb_wf_q;

    logic                load_use, flag_haz;
    logic                ex_hit1, mem_hit1, wb_hit1;
    logic                ex_hit2, mem_hit2, wb_hit2;

    function automatic logic [1:0] fwd_src(input logic ex_hit, input logic mem_hit,
                                           input logic wb_hit);
        if (ex_hit)       return 2'd1;
        else if (mem_hit) return 2'd2;
        else if (wb_hit)  return 2'd3;
        else              return 2'd0;
    endfunction

    // Load results only exist after MEM, so a load in EX never forwards; it stalls instead.
    always_comb begin
        ex_hit1  = rr_use_rs1 & ex_vld_q  & ex_wr_q  & ~ex_ld_q & (ex_rd_q  == rr_rs1);
        mem_hit1 = rr_use_rs1 & mem_vld_q & mem_wr_q & (mem_rd_q == rr_rs1);
        wb_hit1  = rr_use_rs1 & wb_vld_q  & wb_wr_q  & (wb_rd_q  == rr_rs1);
        ex_hit2  = rr_use_rs2 & ex_vld_q  & ex_wr_q  & ~ex_ld_q & (ex_rd_q  == rr_rs2);
        mem_hit2 = rr_use_rs2 & mem_vld_q & mem_wr_q & (mem_rd_q == rr_rs2);
        wb_hit2  = rr_use_rs2 & wb_vld_q  & wb_wr_q  & (wb_rd_q  == rr_rs2);

        load_use = rr_valid & ex_vld_q & ex_wr_q & ex_ld_q &
                   ((rr_use_rs1 & (ex_rd_q == rr_rs1)) | (rr_use_rs2 & (ex_rd_q == rr_rs2)));
        flag_haz = rr_valid & rr_flag_dep & ex_vld_q & ex_wf_q;
    end

    assign fwd1_sel     = fwd_src(ex_hit1, mem_hit1, wb_hit1);
    assign fwd2_sel     = fwd_src(ex_hit2, mem_hit2, wb_hit2);
    assign flag_fwd_sel = (mem_vld_q & mem_wf_q) ? 2'd2 :
                          (wb_vld_q  & wb_wf_q)  ? 2'd3 : 2'd0;

    // The branch cycle itself already flushes, ahead of the FSM entering FLUSH.
    assign flush     = (state_q == FLUSH) | ex_branch;
    assign stall     = (load_use | flag_haz) & ~flush;
    assign ex_bubble = stall | flush;
    assign ex_vld_d  = rr_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            redir_cnt_q <= 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_branch) begin
                        state_q     <= FLUSH;
                        redir_cnt_q <= REDIR_INIT;
                    end
                end
                FLUSH: begin
                    if (redir_cnt_q <= 3'd1) begin
                        state_q     <= RUN;
                        redir_cnt_q <= 3'd0;
                    end else begin
                        redir_cnt_q <= redir_cnt_q - 3'd1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_q  <= 1'b0;
            mem_vld_q <= 1'b0;
            wb_vld_q  <= 1'b0;
        end else begin
            ex_vld_q  <= ex_vld_d;
            mem_vld_q <= ex_vld_q;
            wb_vld_q  <= mem_vld_q;
        end
    end

    // Payload fields are qualified by the valids, so they need no reset.
    always_ff @(posedge clk) begin
        ex_rd_q  <= rr_rd;
        ex_wr_q  <= rr_wr_en;
        ex_ld_q  <= rr_is_load;
        ex_wf_q  <= rr_wr_flags;
        mem_rd_q <= ex_rd_q;
        mem_wr_q <= ex_wr_q;
        mem_wf_q <= ex_wf_q;
        wb_rd_q  <= mem_rd_q;
        wb_wr_q  <= mem_wr_q;
        wb_wf_q  <= mem_wf_q;
    end

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if ((state_q == RUN) && ex_branch)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each vector carries RR stimulus plus expected
// {stall, ex_bubble, flush, fwd1_sel, fwd2_sel, flag_fwd_sel}.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rr_valid, rr_use_rs1, rr_use_rs2, rr_wr_en, rr_is_load;
    logic             rr_wr_flags, rr_flag_dep, ex_branch;
    logic [2:0]       rr_rs1, rr_rs2, rr_rd;
    logic             stall, ex_bubble, flush;
    logic [1:0]       fwd1_sel, fwd2_sel, flag_fwd_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic       vld;
        logic [2:0] rs1;
        logic       u1;
        logic [2:0] rs2;
        logic       u2;
        logic [2:0] rd;
        logic       wr, ld, wf, fd, br, rst;
        logic [8:0] exp;
    } vec_t;

    vec_t sbq[$];

    hazard_ctrl #(.REG_BITS(3), .REDIRECT_LAT(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .rr_valid(rr_valid), .rr_rs1(rr_rs1), .rr_rs2(rr_rs2),
        .rr_use_rs1(rr_use_rs1), .rr_use_rs2(rr_use_rs2), .rr_rd(rr_rd), .rr_wr_en(rr_wr_en),
        .rr_is_load(rr_is_load), .rr_wr_flags(rr_wr_flags), .rr_flag_dep(rr_flag_dep),
        .ex_branch(ex_branch), .stall(stall), .ex_bubble(ex_bubble), .flush(flush),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .flag_fwd_sel(flag_fwd_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [8:0] obs();
        return {stall, ex_bubble, flush, fwd1_sel, fwd2_sel, flag_fwd_sel};
    endfunction

    function automatic void push(string nm, logic vld, logic [2:0] rs1, logic u1,
                                 logic [2:0] rs2, logic u2, logic [2:0] rd, logic wr,
                                 logic ld, logic wf, logic fd, logic br, logic rst,
                                 logic [8:0] exp);
        vec_t v;
        v.name = nm; v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.wr = wr; v.ld = ld; v.wf = wf; v.fd = fd; v.br = br; v.rst = rst;
        v.exp = exp;
        sbq.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        rst_n = v.rst; rr_valid = v.vld; rr_rs1 = v.rs1; rr_use_rs1 = v.u1;
        rr_rs2 = v.rs2; rr_use_rs2 = v.u2; rr_rd = v.rd; rr_wr_en = v.wr;
        rr_is_load = v.ld; rr_wr_flags = v.wf; rr_flag_dep = v.fd; ex_branch = v.br;
    endtask

    task automatic idle(input int n);
        vec_t v;
        v.name = "idle"; v.vld = 0; v.rs1 = 0; v.u1 = 0; v.rs2 = 0; v.u2 = 0; v.rd = 0;
        v.wr = 0; v.ld = 0; v.wf = 0; v.fd = 0; v.br = 0; v.rst = 1; v.exp = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(v);
        end
    endtask

    task automatic test_reset();
        vec_t v;
        v.name = "rst"; v.vld = 1; v.rs1 = 3; v.u1 = 1; v.rs2 = 3; v.u2 = 1; v.rd = 3;
        v.wr = 1; v.ld = 1; v.wf = 1; v.fd = 1; v.br = 0; v.rst = 0; v.exp = 0;
        drive(v);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (obs() !== 9'd0) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: got %b want %b", i, obs(), 9'd0);
            end
        end
        n_cmp++;
        if ({stall_cnt, flush_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        idle(2);
    endtask

    task automatic test_load_use();
        vec_t v;
        idle(3);
        push("lu_lw",      1, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 1, 9'b000_00_00_00);
        push("lu_stall",   1, 3, 1, 2, 1, 4, 1, 0, 1, 0, 0, 1, 9'b110_00_00_00);
        push("lu_fwd_mem", 1, 3, 1, 2, 1, 4, 1, 0, 1, 0, 0, 1, 9'b000_10_00_00);
        push("lu_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b000_00_00_00);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            @(negedge clk); drive(v); #1;
            n_cmp++;
            if (obs() !== v.exp) begin
                n_err++;
                $display("FAIL %s: got %b want %b", v.name, obs(), v.exp);
            end
        end
    endtask

    task automatic test_forward();
        vec_t v;
        idle(3);
        push("fw_add_r1",  1, 2, 1, 3, 1, 1, 1, 0, 1, 0, 0, 1, 9'b000_00_00_00);
        push("fw_ex_ex",   1, 1, 1, 1, 1, 5, 1, 0, 1, 0, 0, 1, 9'b000_01_01_00);
        push("fw_mem",     1, 1, 1, 2, 1, 6, 1, 0, 1, 0, 0, 1, 9'b000_10_00_10);
        push("fw_wb_ex",   1, 1, 1, 6, 1, 2, 1, 0, 1, 0, 0, 1, 9'b000_11_01_10);
        push("fw_ex_both", 1, 2, 1, 2, 1, 3, 1, 0, 1, 0, 0, 1, 9'b000_01_01_10);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            @(negedge clk); drive(v); #1;
            n_cmp++;
            if (obs() !== v.exp) begin
                n_err++;
                $display("FAIL %s: got %b want %b", v.name, obs(), v.exp);
            end
        end
    endtask

    task automatic test_flags();
        vec_t v;
        idle(3);
        push("fl_add",     1, 2, 1, 3, 1, 1, 1, 0, 1, 0, 0, 1, 9'b000_00_00_00);
        push("fl_stall",   1, 5, 1, 6, 1, 4, 1, 0, 1, 1, 0, 1, 9'b110_00_00_00);
        push("fl_fwd_mem", 1, 5, 1, 6, 1, 4, 1, 0, 1, 1, 0, 1, 9'b000_00_00_10);
        push("fl_fwd_wb",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b000_00_00_11);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            @(negedge clk); drive(v); #1;
            n_cmp++;
            if (obs() !== v.exp) begin
                n_err++;
                $display("FAIL %s: got %b want %b", v.name, obs(), v.exp);
            end
        end
        idle(3);
        push("fl_add2",    1, 2, 1, 3, 1, 1, 1, 0, 1, 0, 0, 1, 9'b000_00_00_00);
        push("fl_indep",   1, 2, 1, 0, 0, 7, 1, 1, 0, 0, 0, 1, 9'b000_00_00_00);
        push("fl_nostall", 1, 5, 1, 6, 1, 4, 1, 0, 1, 1, 0, 1, 9'b000_00_00_10);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            @(negedge clk); drive(v); #1;
            n_cmp++;
            if (obs() !== v.exp) begin
                n_err++;
                $display("FAIL %s: got %b want %b", v.name, obs(), v.exp);
            end
        end
    endtask

    task automatic test_branch_flush();
        vec_t v;
        idle(3);
        push("br_lw",      1, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 1, 9'b000_00_00_00);
        push("br_pulse",   1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 1, 1, 9'b011_00_00_00);
        push("br_hold",    1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0, 1, 9'b011_10_00_00);
        push("br_ex_inv",  1, 4, 1, 3, 1, 6, 1, 0, 0, 0, 0, 1, 9'b000_00_11_00);
        push("br_resume",  0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b000_01_00_00);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            @(negedge clk); drive(v); #1;
            n_cmp++;
            if (obs() !== v.exp) begin
                n_err++;
                $display("FAIL %s: got %b want %b", v.name, obs(), v.exp);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        vec_t v;
        idle(3);
        push("rf_lw",      1, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 1, 9'b000_00_00_00);
        push("rf_branch",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9'b011_00_00_00);
        push("rf_rst0",    1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0, 0, 9'b000_00_00_00);
        push("rf_rst1",    1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0, 0, 9'b000_00_00_00);
        push("rf_rst2",    1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0, 0, 9'b000_00_00_00);
        push("rf_first",   1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0, 1, 9'b000_00_00_00);
        push("rf_second",  1, 4, 1, 4, 1, 5, 1, 0, 0, 0, 0, 1, 9'b000_01_01_00);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            @(negedge clk); drive(v); #1;
            n_cmp++;
            if (obs() !== v.exp) begin
                n_err++;
                $display("FAIL %s: got %b want %b", v.name, obs(), v.exp);
            end
        end
    endtask

    task automatic test_perf_counters();
        vec_t v;
        logic [CNT_W-1:0] exp_cnt;
        idle(3);
        for (int batch = 0; batch < 2; batch++) begin
            for (int i = 0; i < 10; i++) begin
                push("pc_lw",    1, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 1, 9'b000_00_00_00);
                push("pc_stall", 1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0, 1, 9'b110_00_00_00);
                push("pc_fwd",   1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0, 1, 9'b000_10_00_00);
            end
            while (sbq.size() != 0) begin
                v = sbq.pop_front();
                @(negedge clk); drive(v); #1;
                n_cmp++;
                if (obs() !== v.exp) begin
                    n_err++;
                    $display("FAIL %s: got %b want %b", v.name, obs(), v.exp);
                end
            end
            idle(1);
            #1;
`ifdef HAZ_PERF_EN
            exp_cnt = (batch == 0) ? CNT_W'(10) : CNT_W'(15);
`else
            exp_cnt = '0;
`endif
            n_cmp++;
            if (stall_cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL stall_cnt batch%0d: got %0d want %0d", batch, stall_cnt, exp_cnt);
            end
        end
        idle(3);
        push("pc_br1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9'b011_00_00_00);
        push("pc_br1_fl",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b011_00_00_00);
        push("pc_br1_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b000_00_00_00);
        push("pc_br2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9'b011_00_00_00);
        push("pc_br2_ign", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9'b011_00_00_00);
        push("pc_br2_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b000_00_00_00);
        push("pc_br3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9'b011_00_00_00);
        push("pc_br3_fl",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b011_00_00_00);
        push("pc_br3_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b000_00_00_00);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            @(negedge clk); drive(v); #1;
            n_cmp++;
            if (obs() !== v.exp) begin
                n_err++;
                $display("FAIL %s: got %b want %b", v.name, obs(), v.exp);
            end
        end
        idle(1);
        #1;
`ifdef HAZ_PERF_EN
        exp_cnt = CNT_W'(3);
`else
        exp_cnt = '0;
`endif
        n_cmp++;
        if (flush_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL flush_cnt: got %0d want %0d", flush_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_flags();
        test_branch_flush();
        test_reset_mid_flush();
        test_perf_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 6-stage core (IF, ID, RR, EX, MEM, WB). It sits beside the RR→EX boundary feeding the alu. It keeps a shadow scoreboard of in-flight destinations in EX, MEM and WB, and from it drives:
- operand and flag forwarding selects;
- load-use and flag-use stalls;
- EX bubble injection;
- branch-redirect flushes.

Parameters:
REG_BITS, 3, width of register specifiers (8 GPRs)
REDIRECT_LAT, 1, extra cycles flush is held after a taken branch (1..7)
CNT_W, 16, width of performance counters (HAZ_PERF_EN only)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
rr_valid  input  1  instruction present in RR
rr_rs1  input  REG_BITS  source register 1
rr_rs2  input  REG_BITS  source register 2
rr_use_rs1  input  1  rs1 is read
rr_use_rs2  input  1  rs2 is read
rr_rd  input  REG_BITS  destination register
rr_wr_en  input  1  instruction writes rd
rr_is_load  input  1  instruction is LW
rr_wr_flags  input  1  instruction updates carry/zero (ADD class, ADDI, NAND class)
rr_flag_dep  input  1  instruction is conditional on carry/zero (ADC/ADZ/ACC/ACZ/AWC/ACW/NDC/NDZ/NCC/NCZ)
ex_branch  input  1  alu branch output (taken) this cycle
stall  output  1  hold IF/ID/RR registers
ex_bubble  output  1  load NOP into EX
flush  output  1  invalidate IF/ID/RR
fwd1_sel  output  2  rs1 source: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
fwd2_sel  output  2  rs2 source, same encoding
flag_fwd_sel  output  2  carry/zero source: 0 arch flags, 2 MEM, 3 WB (1 unused)
stall_cnt  output  CNT_W  stall cycles (HAZ_PERF_EN only)
flush_cnt  output  CNT_W  taken-branch flushes (HAZ_PERF_EN only)

Behaviour:
Shadow entries
- Three shadow entries: ex_, mem_, wb_. Each holds {valid, rd, wr_en, is_load, wr_flags}.
- Every cycle: wb_←mem_, mem_←ex_.
- ex_←RR fields when issue = rr_valid & !stall & !flush. Otherwise ex_ is invalid (bubble).

Load-use hazard
- Raised when rr_valid and, for rs1 and/or rs2: rr_use_rsN & ex_valid & ex_wr_en & ex_is_load & ex_rd==rr_rsN.

Flag hazard
- Raised when rr_valid & rr_flag_dep & ex_valid & ex_wr_flags.
- Flags are forwardable only from MEM onward.

Stall outputs
- Either hazard gives stall=1 and ex_bubble=1 for exactly 1 cycle.
- Next cycle the producer is in MEM, so no hazard remains.

Operand forwarding (combinational, priority EX > MEM > WB)
- A stage matches when valid & wr_en & rd==rsN & use_rsN.
- An EX match with ex_is_load is never selected; it is a stall case.
- No match gives 0.

Flag forwarding
- MEM if mem_valid & mem_wr_flags, else WB if wb_valid & wb_wr_flags, else 0.

State machine
- RUN: a hazard asserts stall and bubble; state stays RUN. ex_branch → FLUSH, loading the redirect counter with REDIRECT_LAT.
- FLUSH: flush=1, ex_bubble=1, stall=0. The counter decrements each cycle; at 0 the next state is RUN.
- In the ex_branch cycle itself, flush=1 and ex_bubble=1 combinationally, so the total flush length is REDIRECT_LAT+1 cycles.
- ex_branch while already in FLUSH is ignored.

Priority
- flush overrides stall: branch and hazard in the same cycle give stall=0, flush=1.
- The branch instruction itself is already in EX and proceeds normally to MEM.

Reset
- Asynchronous and immediate, including mid-stall or mid-FLUSH.
- All shadow valids=0, state=RUN, counter=0.
- Outputs: stall=0, ex_bubble=0, flush=0, fwd*=0.

Optional Feature:
HAZ_PERF_EN
- Defined: stall_cnt increments on each cycle with stall=1. flush_cnt increments on each RUN→FLUSH transition. Both saturate at all-ones and reset to 0.
- Undefined: both ports tie to 0 and no counter flops exist.

Test Plan:
1. LW r3 issues, then ADD r4,r3,r2 in RR next cycle → stall=1, ex_bubble=1 for exactly 1 cycle; the following cycle fwd1_sel=2 (MEM).
2. ADD r1 then NAND r5,r1,r1 back-to-back → no stall; fwd1_sel=1 and fwd2_sel=1. Third consecutive dependent instruction using r1 after one unrelated instruction → fwd1_sel=2.
3. ADD (wr_flags) followed by ADC → 1-cycle stall, then flag_fwd_sel=2. With one independent instruction between them → no stall, flag_fwd_sel=2.
4. REDIRECT_LAT=1, ex_branch pulse while RR holds a load-use hazard → flush=1 for 2 cycles, stall=0 throughout, shadow ex_ invalid for 2 issues.
5. rst_n low mid-FLUSH, released after 3 cycles → all outputs 0 immediately; first post-reset instruction issues with fwd sels 0.
6. HAZ_PERF_EN with CNT_W=4: 20 load-use stalls → stall_cnt=15 (saturated); 3 branches → flush_cnt=3.
